// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character LCD write driver.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC,
    ST_PWR_WAIT,
    ST_INIT_ISSUE
  } lcd_state_e;

  localparam int LCD_ON_BIT   = 31;
  localparam int LCD_RS_BIT   = 9;
  localparam int LCD_DATA_MSB = 7;

  localparam int INIT_LEN = 6;
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  function automatic logic is_clear_home(input logic rs, input logic [7:0] data);
    return !rs && (data[7:1] == 7'd0) && (data != 8'd0);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; done is high while the count reads 1.
module lcd_timer #(
  parameter int         W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write-cycle sequencer: turns LCD register stores into timed EN pulses.
// Define LCD_INIT_EN to run the power-up wait and built-in init sequence after reset.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC   = 4,
  parameter int PULSE_CYC   = 24,
  parameter int HOLD_CYC    = 4,
  parameter int EXEC_CYC    = 2000,
  parameter int CLEAR_CYC   = 82000,
  parameter int POWERUP_CYC = 750000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lcd_word,
  input  logic        i_lcd_wr,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_busy,
  output logic        o_lcd_drop,
  output lcd_state_e  o_state
);

  localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYC, PULSE_CYC), max_int(HOLD_CYC, EXEC_CYC)),
                                   max_int(CLEAR_CYC, POWERUP_CYC));
  localparam int CW = $clog2(MAX_CYC + 1);

`ifdef LCD_INIT_EN
  localparam lcd_state_e RST_STATE = ST_PWR_WAIT;
  localparam logic       RST_BUSY  = 1'b1;
  localparam int         TMR_RST   = POWERUP_CYC;
`else
  localparam lcd_state_e RST_STATE = ST_IDLE;
  localparam logic       RST_BUSY  = 1'b0;
  localparam int         TMR_RST   = 0;
`endif

  lcd_state_e    state;
  logic          armed;
  logic          accept;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_done;
  logic          unused_word;

`ifdef LCD_INIT_EN
  logic          init_active;
  logic [2:0]    init_idx;
`endif

  assign unused_word = ^{i_lcd_word[30:LCD_RS_BIT+1], i_lcd_word[LCD_RS_BIT-1:LCD_DATA_MSB+1]};

  // armed blocks a strobe that coincides with the first edge after reset release.
  assign accept   = armed && i_lcd_wr && (state == ST_IDLE);
  assign o_lcd_rw = 1'b0;
  assign o_state  = state;

  lcd_timer #(
    .W       (CW),
    .RST_VAL (CW'(TMR_RST))
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Timer reload accompanies every state entry that needs a timed stay.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        tmr_load = accept;
        tmr_val  = CW'(SETUP_CYC);
      end
`ifdef LCD_INIT_EN
      ST_INIT_ISSUE: begin
        tmr_load = 1'b1;
        tmr_val  = CW'(SETUP_CYC);
      end
`endif
      ST_SETUP: begin
        tmr_load = tmr_done;
        tmr_val  = CW'(PULSE_CYC);
      end
      ST_PULSE: begin
        tmr_load = tmr_done;
        tmr_val  = CW'(HOLD_CYC);
      end
      ST_HOLD: begin
        tmr_load = tmr_done;
        tmr_val  = is_clear_home(o_lcd_rs, o_lcd_data) ? CW'(CLEAR_CYC) : CW'(EXEC_CYC);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= RST_STATE;
      armed      <= 1'b0;
      o_lcd_on   <= 1'b0;
      o_lcd_en   <= 1'b0;
      o_lcd_rs   <= 1'b0;
      o_lcd_data <= 8'h00;
      o_lcd_busy <= RST_BUSY;
      o_lcd_drop <= 1'b0;
`ifdef LCD_INIT_EN
      init_active <= 1'b1;
      init_idx    <= 3'd0;
`endif
    end else begin
      armed <= 1'b1;
      if (armed && i_lcd_wr) begin
        o_lcd_on <= i_lcd_word[LCD_ON_BIT];
        if (state != ST_IDLE) o_lcd_drop <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            o_lcd_rs   <= i_lcd_word[LCD_RS_BIT];
            o_lcd_data <= i_lcd_word[LCD_DATA_MSB:0];
            o_lcd_drop <= 1'b0;
            o_lcd_busy <= 1'b1;
            state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr_done) begin
            o_lcd_en <= 1'b1;
            state    <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (tmr_done) begin
            o_lcd_en <= 1'b0;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tmr_done) state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (tmr_done) begin
`ifdef LCD_INIT_EN
            if (init_active && (init_idx != 3'(INIT_LEN - 1))) begin
              init_idx <= init_idx + 3'd1;
              state    <= ST_INIT_ISSUE;
            end else begin
              init_active <= 1'b0;
              o_lcd_busy  <= 1'b0;
              state       <= ST_IDLE;
            end
`else
            o_lcd_busy <= 1'b0;
            state      <= ST_IDLE;
`endif
          end
        end
`ifdef LCD_INIT_EN
        ST_PWR_WAIT: begin
          if (tmr_done) state <= ST_INIT_ISSUE;
        end
        ST_INIT_ISSUE: begin
          o_lcd_rs   <= 1'b0;
          o_lcd_data <= INIT_ROM[init_idx];
          state      <= ST_SETUP;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl; the LCD_INIT_EN build runs the init-sequence scenario instead.
module tb_lcd_ctrl;
  import lcd_pkg::*;

`ifdef LCD_INIT_EN
  localparam int SETUP_CYC = 2, PULSE_CYC = 3, HOLD_CYC = 2, EXEC_CYC = 5, CLEAR_CYC = 10, POWERUP_CYC = 100;
`else
  localparam int SETUP_CYC = 4, PULSE_CYC = 24, HOLD_CYC = 4, EXEC_CYC = 2000, CLEAR_CYC = 8000, POWERUP_CYC = 100;
`endif
  localparam int LIMIT = 20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] word = '0;
  logic        wr = 1'b0;
  logic        lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_busy, lcd_drop;
  logic [7:0]  lcd_data;
  lcd_state_e  dut_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  lcd_ctrl #(
    .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .HOLD_CYC(HOLD_CYC),
    .EXEC_CYC(EXEC_CYC), .CLEAR_CYC(CLEAR_CYC), .POWERUP_CYC(POWERUP_CYC)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_lcd_word(word), .i_lcd_wr(wr),
    .o_lcd_on(lcd_on), .o_lcd_en(lcd_en), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw),
    .o_lcd_data(lcd_data), .o_lcd_busy(lcd_busy), .o_lcd_drop(lcd_drop), .o_state(dut_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a strobe in the current cycle; returns at the sample point of the next cycle.
  task automatic strobe(input logic [31:0] w);
    word = w;
    wr   = 1'b1;
    step();
    wr   = 1'b0;
  endtask

  // Called right after strobe(): n counts cycles from the strobe cycle.
  task automatic measure(output int rise, output int width, output int blen);
    int n;
    n = 1;
    width = 0;
    while (!lcd_en && n < LIMIT) begin step(); n++; end
    rise = n;
    while (lcd_en && width < LIMIT) begin width++; step(); n++; end
    while (lcd_busy && n < 3 * LIMIT) begin step(); n++; end
    blen = n;
  endtask

  task automatic wait_busy_low();
    int n;
    n = 0;
    while (lcd_busy && n < 3 * LIMIT) begin step(); n++; end
    check("busy_timeout", {31'd0, lcd_busy}, 32'd0);
  endtask

  initial begin
    int rise, width, blen;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

`ifdef LCD_INIT_EN
    exp_q = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    check("init_rst_busy", {31'd0, lcd_busy}, 32'd1);
    check("init_rst_state", {29'd0, dut_state}, {29'd0, ST_PWR_WAIT});
    strobe(32'h0000_0141);
    check("init_drop", {31'd0, lcd_drop}, 32'd1);
    check("init_drop_on", {31'd0, lcd_on}, 32'd0);
    for (int i = 0; i < INIT_LEN; i++) begin
      int n;
      logic [7:0] e;
      n = 0;
      while (!lcd_en && n < LIMIT) begin step(); n++; end
      e = exp_q.pop_front();
      check($sformatf("init_data%0d", i), {24'd0, lcd_data}, {24'd0, e});
      check($sformatf("init_rs%0d", i), {31'd0, lcd_rs}, 32'd0);
      n = 0;
      while (lcd_en && n < LIMIT) begin step(); n++; end
      check($sformatf("init_width%0d", i), n, PULSE_CYC);
    end
    wait_busy_low();
    check("init_done_data", {24'd0, lcd_data}, 32'h06);
    strobe(32'h8000_0241);
    check("init_acc_busy", {31'd0, lcd_busy}, 32'd1);
    check("init_acc_data", {24'd0, lcd_data}, 32'h41);
    check("init_acc_drop", {31'd0, lcd_drop}, 32'd0);
    wait_busy_low();
`else
    // reset values
    check("rst_on", {31'd0, lcd_on}, 32'd0);
    check("rst_en", {31'd0, lcd_en}, 32'd0);
    check("rst_rs", {31'd0, lcd_rs}, 32'd0);
    check("rst_rw", {31'd0, lcd_rw}, 32'd0);
    check("rst_data", {24'd0, lcd_data}, 32'd0);
    check("rst_busy", {31'd0, lcd_busy}, 32'd0);
    check("rst_drop", {31'd0, lcd_drop}, 32'd0);
    check("rst_state", {29'd0, dut_state}, {29'd0, ST_IDLE});

    // data write 0x41, RS=1
    step();
    strobe(32'h8000_0241);
    check("a_on", {31'd0, lcd_on}, 32'd1);
    check("a_rs", {31'd0, lcd_rs}, 32'd1);
    check("a_data", {24'd0, lcd_data}, 32'h41);
    check("a_busy", {31'd0, lcd_busy}, 32'd1);
    measure(rise, width, blen);
    check("a_rise", rise, 5);
    check("a_width", width, 24);
    check("a_busy_len", blen, 2033);
    check("a_idle_rs", {31'd0, lcd_rs}, 32'd1);
    check("a_idle_data", {24'd0, lcd_data}, 32'h41);
    check("a_rw", {31'd0, lcd_rw}, 32'd0);

    // clear display in the same cycle busy fell
    strobe(32'h8000_0001);
    check("b_busy", {31'd0, lcd_busy}, 32'd1);
    check("b_rs", {31'd0, lcd_rs}, 32'd0);
    check("b_data", {24'd0, lcd_data}, 32'h01);
    measure(rise, width, blen);
    check("b_rise", rise, 5);
    check("b_width", width, 24);
    check("b_busy_len", blen, 1 + 4 + 24 + 4 + CLEAR_CYC);

    // write while busy is dropped
    strobe(32'h8000_0241);
    repeat (98) step();
    strobe(32'h0000_0242);
    check("c_drop", {31'd0, lcd_drop}, 32'd1);
    check("c_data", {24'd0, lcd_data}, 32'h41);
    check("c_rs", {31'd0, lcd_rs}, 32'd1);
    check("c_on", {31'd0, lcd_on}, 32'd0);
    check("c_busy", {31'd0, lcd_busy}, 32'd1);
    wait_busy_low();
    check("c_drop_sticky", {31'd0, lcd_drop}, 32'd1);
    strobe(32'h8000_0130);
    check("c_drop_clr", {31'd0, lcd_drop}, 32'd0);
    check("c_on2", {31'd0, lcd_on}, 32'd1);
    check("c_rs2", {31'd0, lcd_rs}, 32'd0);
    check("c_data2", {24'd0, lcd_data}, 32'h30);
    measure(rise, width, blen);
    check("c_busy_len", blen, 2033);

    // reset during EN pulse
    strobe(32'h8000_0248);
    measure(rise, width, blen);
    strobe(32'h8000_0248);
    repeat (7) step();
    check("d_en_pre", {31'd0, lcd_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("d_en_async", {31'd0, lcd_en}, 32'd0);
    check("d_busy_async", {31'd0, lcd_busy}, 32'd0);
    check("d_on_async", {31'd0, lcd_on}, 32'd0);
    step();
    rst_n = 1'b1;
    word  = 32'h8000_0255;
    wr    = 1'b1;
    step();
    wr    = 1'b0;
    check("d_rel_busy", {31'd0, lcd_busy}, 32'd0);
    check("d_rel_on", {31'd0, lcd_on}, 32'd0);
    check("d_rel_data", {24'd0, lcd_data}, 32'd0);
    strobe(32'h8000_0242);
    check("d_data", {24'd0, lcd_data}, 32'h42);
    measure(rise, width, blen);
    check("d_rise", rise, 5);
    check("d_width", width, 24);
    check("d_busy_len", blen, 2033);
    check("d_rw", {31'd0, lcd_rw}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Hardware driver for the HD44780-compatible character LCD. It sits on the output side of the load-store unit and turns stores to the LCD register into correctly timed LCD bus write cycles, so software does not bit-bang EN. It also returns a busy flag and a sticky drop flag that are mapped into the input region for software to poll.

## Interface
Parameters:
- SETUP_CYC, default 4: cycles RS/DATA are stable before EN rises.
- PULSE_CYC, default 24: EN high width in cycles (≥450 ns at 50 MHz).
- HOLD_CYC, default 4: cycles RS/DATA are held after EN falls.
- EXEC_CYC, default 2000: post-write wait for normal commands and data (40 µs).
- CLEAR_CYC, default 82000: post-write wait for clear/home (1.64 ms).
- POWERUP_CYC, default 750000: power-on wait, used only with LCD_INIT_EN (15 ms).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset; clock i_clk.
- i_lcd_word  in  32  LCD register value from the LSU: [31] ON, [9] RS, [7:0] DATA; other bits ignored.
- i_lcd_wr  in  1  one-cycle strobe: the LSU stored to the LCD register this cycle.
- o_lcd_on  out  1  LCD power/backlight enable.
- o_lcd_en  out  1  LCD EN pin.
- o_lcd_rs  out  1  LCD RS pin.
- o_lcd_rw  out  1  LCD RW pin, constant 0 (write-only driver).
- o_lcd_data  out  8  LCD data bus.
- o_lcd_busy  out  1  high while a transaction or init is in progress.
- o_lcd_drop  out  1  sticky: a write arrived while busy and was discarded.

## Operation
- States: IDLE, SETUP, PULSE, HOLD, EXEC; plus PWR_WAIT and INIT_ISSUE when LCD_INIT_EN is defined.
- Accept: i_lcd_wr=1 and busy=0 in IDLE. RS and DATA are latched into o_lcd_rs and o_lcd_data, and the FSM goes to SETUP.
- SETUP (en=0, SETUP_CYC) -> PULSE (en=1, PULSE_CYC) -> HOLD (en=0, HOLD_CYC) -> EXEC (wait) -> IDLE.
- EXEC length is CLEAR_CYC when RS=0 and DATA[7:1]==7'b0000000 with DATA≠0 (0x01, 0x02, 0x03). Otherwise it is EXEC_CYC.
- A single down-counter, wide enough for the largest parameter, is reloaded on each state entry. The state advances when the counter reads 1.
- o_lcd_on is updated from word[31] on every i_lcd_wr, including dropped writes.
- A write while busy is discarded and sets o_lcd_drop. The flag clears on the next accepted write.
- o_lcd_rs and o_lcd_data hold their last values in IDLE.
- Reset values: on=0, en=0, rs=0, rw=0, data=0x00, drop=0. busy=0 (or 1 with LCD_INIT_EN). FSM starts in IDLE (or PWR_WAIT with LCD_INIT_EN).
- Reset mid-transaction aborts immediately. EN drops asynchronously and no partial pulse is completed.

## Timing
- Accept in cycle t: busy, rs and data are registered high/valid at t+1. EN rises at t+1+SETUP_CYC.
- EN high for exactly PULSE_CYC cycles.
- busy deasserts at t+1+SETUP_CYC+PULSE_CYC+HOLD_CYC+EXEC (EXEC = EXEC_CYC or CLEAR_CYC).
- A write in the same cycle busy falls is accepted. Back-to-back throughput is one write per busy period + 1 cycle.
- i_lcd_wr simultaneous with reset deassertion is ignored.

## Configuration
- LCD_INIT_EN defined:
  - After reset, the FSM waits POWERUP_CYC in PWR_WAIT with busy=1.
  - It then issues the 6-entry ROM 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with RS=0, each through SETUP/PULSE/HOLD/EXEC (0x01 uses CLEAR_CYC), then goes to IDLE.
  - Writes during init are dropped and set drop.
- LCD_INIT_EN undefined: IDLE right after reset with busy=0. Software performs the init sequence.

## Structure
- Shared package lcd_pkg:
  - state enum.
  - word bit-position constants (LCD_ON_BIT=31, LCD_RS_BIT=9, LCD_DATA_MSB=7).
  - init ROM array and length.
  - clear/home decode function.
- One sub-module, lcd_timer: loadable down-counter with load value and done flag, parameterized width. The FSM instantiates it once.

## Test plan
- Reset and release, no LCD_INIT_EN -> all outputs 0, busy=0, rw=0 throughout the test.
- Strobe word 0x8000_0241 -> on=1, rs=1, data=0x41; EN high 24 cycles starting 5 cycles after the strobe; busy low after 2033 cycles.
- Strobe 0x8000_0001 -> same EN timing; busy lasts 1+4+24+4+82000 cycles.
- Second strobe 0x0000_0242 at cycle 100 of the first transaction -> drop=1, data stays 0x41, on=0. Next accepted write clears drop.
- Assert i_rst_n=0 while EN is high -> en=0 and busy=0 immediately; the next write runs a full, normal cycle.
- With LCD_INIT_EN, POWERUP_CYC=100 and small timing parameters -> six EN pulses with data 38, 38, 38, 0C, 01, 06; then busy falls and a write is accepted.
